qft_phase_sequencer: RTL
========================

# qft_phase_sequencer

Generates the QFT twiddle-phase stream θ(j,k) = 2π·j·k/N in signed fixed point, wrapped to [-π, π). Each angle is emitted on a valid/ready output for the downstream piecewise-linear cosine stage, which evaluates cos(θ) for the real part of each twiddle factor. The phase is tracked as an exact integer index modulo N, so accumulated angles never drift. A start pulse sweeps the full N×N (j,k) grid, one angle per accepted transfer.

## Interface
- N_LOG2, 3: log2 of QFT size N; 1..6.
- TWO_PI_Q, 101: 2π in Q(`FRAC_WIDTH) fixed point; must satisfy |TWO_PI_Q/2| < 2^(`TOTAL_WIDTH-1).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- busy  output  1  high while a sweep is in progress.
- out_valid  output  1  angle word valid.
- out_ready  input  1  downstream accepts the word when high with out_valid.
- angle  output  `TOTAL_WIDTH  signed θ in Q(`FRAC_WIDTH); connects directly to the cosine stage input x.
- row_j  output  N_LOG2  j index of the current word.
- col_k  output  N_LOG2  k index of the current word.
- last  output  1  high with the final word of a sweep (j = k = N-1).
- done  output  1  one-cycle pulse after the last word is accepted.
- inv  input  1  present only with QFT_INVERSE_EN; selects the inverse (conjugate) phase.

## Operation
- States: IDLE and RUN.
- **IDLE → RUN** on start=1. Set j=0, k=0, idx=0, and load the first output register.
- **RUN, transfer** (out_valid && out_ready):
  - If k<N-1: k+1, and idx ← (idx + j) mod N, using N_LOG2-bit wrap.
  - Else if j<N-1: j+1, k=0, idx=0.
  - Else: RUN → IDLE, out_valid←0, done←1 for one cycle.
- **Angle conversion:**
  - Interpret idx as N_LOG2+1-bit signed s = idx − N when idx ≥ N/2, else s = idx.
  - angle = (s × TWO_PI_Q) >>> N_LOG2, an arithmetic shift (floor), truncated to `TOTAL_WIDTH.
  - s = −N/2 maps to −π.
  - The product width is (N_LOG2+1)+`TOTAL_WIDTH bits signed.
- angle, row_j, col_k and last are registered. They must hold stable while out_valid=1 and out_ready=0.
- start during RUN is ignored. A start arriving together with the final transfer is ignored; the block is in IDLE only from the following cycle.
- rst at any time, including mid-sweep: go to IDLE. out_valid, busy, done, last, angle, row_j and col_k all become 0. Any partial sweep is discarded.
- Reset values: all outputs 0.

## Timing
- start sampled high at edge t → out_valid=1 and busy=1 after edge t, with the first word present (j=0, k=0, angle=0).
- Throughput is one word per cycle under continuous out_ready=1, with no bubbles between rows.
- A full sweep is N² transfers. With out_ready held high, the sweep occupies cycles t+1..t+N².
- After the edge that accepts the last word: out_valid=0, busy=0, done=1. done clears on the next edge.
- out_ready has no combinational path to out_valid. out_valid is asserted independently of out_ready.

## Configuration
- **QFT_INVERSE_EN defined:**
  - The inv port exists and is sampled with start; it stays fixed for the whole sweep.
  - inv=1 uses idx' = (N − idx) mod N before conversion, giving θ = −2π·j·k/N wrapped to [-π, π). idx=N/2 still maps to −π.
- **QFT_INVERSE_EN undefined:** no inv port; forward phase only.

## Test plan
All scenarios use N_LOG2=3 and TWO_PI_Q=101.

- **Reset:** rst=1 for 2 cycles → all outputs 0. Release with no start → outputs remain 0 and busy=0.
- **Forward sweep, out_ready=1:**
  - Exactly 64 words.
  - Row j=1 angles: 0, 12, 25, 37, −51, −38, −26, −13.
  - Row j=4 angles: 0, −51, 0, −51, 0, −51, 0, −51.
  - last only at (7,7), with angle 12.
  - done pulses on the cycle after (7,7) is accepted; busy falls on the same cycle.
- **Backpressure:** drop out_ready for 3 cycles while (j=2, k=3) is presented → angle=−26, row_j=2, col_k=3 held stable for all 3 cycles. Next word after release is (2,4) with angle 0. No word is lost or duplicated.
- **Start while busy / reset mid-sweep:**
  - start pulsed at word 10 → ignored; the sweep still yields 64 words.
  - rst at word 20 → out_valid=0 next cycle and done is never pulsed.
  - A subsequent start begins again at (0,0).
- **Inverse (QFT_INVERSE_EN, inv=1):** row j=1 angles: 0, −13, −26, −38, −51, 37, 25, 12. Row j=0 is all 0.
- **Downstream link:** feed angle to the cosine stage → j=0 rows give cos ≈ 16 (1.0 in Q4), and angle −51 gives ≈ −16.

Source files
------------

// File: rtl/qft_phase_sequencer.sv
// QFT twiddle-phase sequencer: sweeps the N x N (j,k) grid and emits 2*pi*j*k/N wrapped to [-pi, pi).
// Optional inverse phase selection is compiled in with QFT_INVERSE_EN.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 4
`endif

module qft_phase_sequencer #(
   parameter int N_LOG2   = 3,
   parameter int TWO_PI_Q = 101
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [`TOTAL_WIDTH-1:0]   angle,
   output logic [N_LOG2-1:0]         row_j,
   output logic [N_LOG2-1:0]         col_k,
   output logic                      last,
   output logic                      done
`ifdef QFT_INVERSE_EN
   ,input  logic                     inv
`endif
);

   localparam int TW = `TOTAL_WIDTH;
   localparam int PW = N_LOG2 + 1 + TW;
   localparam logic [N_LOG2-1:0] IDX_MAX = {N_LOG2{1'b1}};
   localparam logic signed [PW-1:0] TWO_PI_EXT = PW'(TWO_PI_Q);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [N_LOG2-1:0]   j_q, j_d;
   logic [N_LOG2-1:0]   k_q, k_d;
   logic [N_LOG2-1:0]   idx_q, idx_d;
   logic [TW-1:0]       angle_q, angle_d;
   logic                last_q, last_d;
   logic                done_q, done_d;
   logic                inv_q, inv_d;
   logic                inv_start_s;
   logic [N_LOG2-1:0]   idx_eff_s;

`ifdef QFT_INVERSE_EN
   assign inv_start_s = inv;
`else
   assign inv_start_s = 1'b0;
`endif

   // Sign-extending the index reinterprets idx >= N/2 as idx - N, so N/2 lands on -pi.
   function automatic logic [TW-1:0] idx_to_angle(input logic [N_LOG2-1:0] ix);
      logic signed [PW-1:0] s_ext;
      logic signed [PW-1:0] prod;
      s_ext = {{(PW-N_LOG2){ix[N_LOG2-1]}}, ix};
      prod  = (s_ext * TWO_PI_EXT) >>> N_LOG2;
      return prod[TW-1:0];
   endfunction

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      k_d     = k_q;
      idx_d   = idx_q;
      inv_d   = inv_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               j_d     = '0;
               k_d     = '0;
               idx_d   = '0;
               inv_d   = inv_start_s;
            end
         end
         RUN: begin
            if (out_ready) begin
               if (k_q != IDX_MAX) begin
                  k_d   = k_q + 1'b1;
                  idx_d = idx_q + j_q;
               end else if (j_q != IDX_MAX) begin
                  j_d   = j_q + 1'b1;
                  k_d   = '0;
                  idx_d = '0;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Inverse phase is the modular negation of the index.
      idx_eff_s = inv_d ? (N_LOG2'(0) - idx_d) : idx_d;
      angle_d   = idx_to_angle(idx_eff_s);
      last_d    = (state_d == RUN) && (j_d == IDX_MAX) && (k_d == IDX_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         j_q     <= '0;
         k_q     <= '0;
         idx_q   <= '0;
         inv_q   <= 1'b0;
         angle_q <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         k_q     <= k_d;
         idx_q   <= idx_d;
         inv_q   <= inv_d;
         angle_q <= angle_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign out_valid = (state_q == RUN);
   assign angle     = angle_q;
   assign row_j     = j_q;
   assign col_k     = k_q;
   assign last      = last_q;
   assign done      = done_q;

endmodule
